// File: rtl/aes_inv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_pkg
// Purpose  : Shared types, constants and GF(2^8) helpers for the sequenced
//            InvMixColumns engine (FSM state enum, coefficients, widths).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_inv_pkg;

   localparam int COL_W    = 32;
   localparam int STATE_W  = 128;
   localparam int NUM_COLS = 4;

   localparam logic [7:0] COEF_E   = 8'h0E;
   localparam logic [7:0] COEF_B   = 8'h0B;
   localparam logic [7:0] COEF_D   = 8'h0D;
   localparam logic [7:0] COEF_9   = 8'h09;
   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

   // Multiply by a constant below 16 using the x, x^2, x^3 multiples.
   // With a constant coefficient the unused terms fold away.
   function automatic logic [7:0] gmul_const(input logic [7:0] a, input logic [7:0] coef);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (coef[0] ? a  : 8'h00) ^ (coef[1] ? x2 : 8'h00) ^
             (coef[2] ? x4 : 8'h00) ^ (coef[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [7:0] gmul_9(input logic [7:0] a);
      return gmul_const(a, COEF_9);
   endfunction

   function automatic logic [7:0] gmul_b(input logic [7:0] a);
      return gmul_const(a, COEF_B);
   endfunction

   function automatic logic [7:0] gmul_d(input logic [7:0] a);
      return gmul_const(a, COEF_D);
   endfunction

   function automatic logic [7:0] gmul_e(input logic [7:0] a);
      return gmul_const(a, COEF_E);
   endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mix_column_unit.sv
`default_nettype none
// ============================================================================
// Module   : inv_mix_column_unit
// Purpose  : Combinational InvMixColumns of one 32-bit column.
// Ports    : col_i [31:0] column in,  row r = bits [8r+7:8r]
//            col_o [31:0] column out, same packing
// Revision : 1.0 - initial release
// ============================================================================
module inv_mix_column_unit
   import aes_inv_pkg::*;
(
   input  logic [COL_W-1:0] col_i,
   output logic [COL_W-1:0] col_o
);

   logic [7:0] w_s0, w_s1, w_s2, w_s3;

   assign w_s0 = col_i[7:0];
   assign w_s1 = col_i[15:8];
   assign w_s2 = col_i[23:16];
   assign w_s3 = col_i[31:24];

   assign col_o[7:0]   = gmul_e(w_s0) ^ gmul_b(w_s1) ^ gmul_d(w_s2) ^ gmul_9(w_s3);
   assign col_o[15:8]  = gmul_9(w_s0) ^ gmul_e(w_s1) ^ gmul_b(w_s2) ^ gmul_d(w_s3);
   assign col_o[23:16] = gmul_d(w_s0) ^ gmul_9(w_s1) ^ gmul_e(w_s2) ^ gmul_b(w_s3);
   assign col_o[31:24] = gmul_b(w_s0) ^ gmul_d(w_s1) ^ gmul_9(w_s2) ^ gmul_e(w_s3);

endmodule
`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_mix_columns_seq
// Purpose  : Sequenced InvMixColumns engine. A 128-bit state is accepted over
//            valid/ready, pushed through COLS_PER_CYCLE shared column units
//            per clock, and presented over valid/ready from a result register.
// Params   : COLS_PER_CYCLE  columns per BUSY cycle (1, 2 or 4)
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   data_in valid
//            in_ready   engine accepts data_in this cycle
//            data_in    [127:0] state, column c = [32c+31:32c]
//            out_valid  data_out valid
//            out_ready  consumer takes data_out this cycle
//            data_out   [127:0] InvMixColumns(data_in)
//            busy       high while columns are being processed
// Revision : 1.0 - initial release
// ============================================================================
module inv_mix_columns_seq
   import aes_inv_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] data_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] data_out,
   output logic               busy
);

   // Step of 4 truncates to 0, which is the desired 2-bit wrap.
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   state_e             state_q, state_d;
   logic [1:0]         col_cnt_q, col_cnt_d;
   logic [STATE_W-1:0] data_q, data_d;
   logic [STATE_W-1:0] result_q, result_d;

   logic [1:0]         w_col_idx  [COLS_PER_CYCLE];
   logic [COL_W-1:0]   w_unit_in  [COLS_PER_CYCLE];
   logic [COL_W-1:0]   w_unit_out [COLS_PER_CYCLE];

   // Column group currently in flight: col_cnt .. col_cnt+COLS_PER_CYCLE-1.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
      assign w_col_idx[g] = col_cnt_q + 2'(g);
      assign w_unit_in[g] = data_q[COL_W*w_col_idx[g] +: COL_W];

      inv_mix_column_unit u_col (
         .col_i (w_unit_in[g]),
         .col_o (w_unit_out[g])
      );
   end

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      data_d    = data_q;
      result_d  = result_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d    = data_in;
               col_cnt_d = 2'd0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int c = 0; c < NUM_COLS; c++) begin
               for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                  if (w_col_idx[g] == 2'(c)) begin
                     result_d[COL_W*c +: COL_W] = w_unit_out[g];
                  end
               end
            end
            col_cnt_d = col_cnt_q + COL_STEP;
            if (col_cnt_q == LAST_COL) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  // Back-to-back: hand off the result and load the next block.
                  data_d    = data_in;
                  col_cnt_d = 2'd0;
                  state_d   = ST_BUSY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         col_cnt_q <= 2'd0;
         data_q    <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         data_q    <= data_d;
         result_q  <= result_d;
      end
   end

   // Gated by rst_n so nothing is offered as acceptable while reset is held.
   assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_BUSY);
   assign data_out  = result_q;

endmodule
`default_nettype wire
